fphub_div_sequencer: RTL and testbench



---
 rtl/fphub_div_sequencer_if.sv | 32 +++
 rtl/fphub_div_sequencer.sv | 126 ++++++++++++
 tb/tb_fphub_div_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fphub_div_sequencer_if.sv
// Operand/result handshake bundle for the HUB divider sequencer.
// The master side drives operands and out_ready; the slave side is the sequencer.
interface fphub_div_sequencer_if #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7
);
  localparam int W  = E + M + 1;
  localparam int CW = $clog2(special_case);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic [CW-1:0] X_special_case;
  logic [CW-1:0] Y_special_case;
  logic [W-1:0]  special_result;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Z;
  logic          out_special;

  modport master (
    output in_valid, X, Y, X_special_case, Y_special_case, special_result, out_ready,
    input  in_ready, out_valid, Z, out_special
  );

  modport slave (
    input  in_valid, X, Y, X_special_case, Y_special_case, special_result, out_ready,
    output in_ready, out_valid, Z, out_special
  );
endinterface

// File: rtl/fphub_div_sequencer.sv
// HUB floating-point divider sequencer: special-case bypass or restoring
// significand division, then exponent adjust, truncation and range clamp.
module fphub_div_sequencer #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7
) (
  input logic                   clk,
  input logic                   rst,
  fphub_div_sequencer_if.slave  bus
);
  localparam int W  = E + M + 1;
  localparam int NW = $clog2(M + 2);
  localparam int EW = E + 2;

  localparam logic [NW-1:0]        LAST_IT  = NW'(M + 1);
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (E - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                 state;
  logic                   sign;
  logic signed [EW-1:0]   e_tmp;
  logic [M+1:0]           my;
  logic [M+2:0]           rem;
  logic [M+1:0]           q;
  logic [NW-1:0]          cnt;
  logic                   out_valid_r;
  logic [W-1:0]           z_r;
  logic                   out_special_r;

  logic [M+3:0]           diff;
  logic                   t_ge;
  logic [M+2:0]           rem_sel;
  logic                   is_special;

  // Clamp to signed INF / signed zero outside the representable exponent range.
  function automatic logic [W-1:0] pack_z(input logic s,
                                          input logic signed [EW-1:0] ex,
                                          input logic [M-1:0] mant);
    if (ex >= EXP_MAX)
      pack_z = {s, {E{1'b1}}, {M{1'b1}}};
    else if (ex <= EXP_ZERO)
      pack_z = {s, {(E + M){1'b0}}};
    else
      pack_z = {s, ex[E-1:0], mant};
  endfunction

  // One restoring step: the extra top bit of diff is the borrow (t < 0).
  assign diff       = {1'b0, rem} - {2'b00, my};
  assign t_ge       = ~diff[M+3];
  assign rem_sel    = t_ge ? diff[M+2:0] : rem;
  assign is_special = (|bus.X_special_case) || (|bus.Y_special_case);

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.Z           = z_r;
  assign bus.out_special = out_special_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sign          <= 1'b0;
      e_tmp         <= '0;
      my            <= '0;
      rem           <= '0;
      q             <= '0;
      cnt           <= '0;
      out_valid_r   <= 1'b0;
      z_r           <= '0;
      out_special_r <= 1'b0;
    end else begin
      case (state)
        // Accept: either latch the bypass result or set up the division.
        IDLE: begin
          if (bus.in_valid) begin
            if (is_special) begin
              z_r           <= bus.special_result;
              out_special_r <= 1'b1;
              out_valid_r   <= 1'b1;
              state         <= DONE;
            end else begin
              sign  <= bus.X[W-1] ^ bus.Y[W-1];
              e_tmp <= $signed({2'b00, bus.X[W-2:M]}) - $signed({2'b00, bus.Y[W-2:M]}) + BIAS;
              rem   <= {2'b01, bus.X[M-1:0], 1'b1};
              my    <= {1'b1, bus.Y[M-1:0], 1'b1};
              q     <= '0;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        // Iterate: one quotient bit per cycle, MSB first.
        DIV: begin
          rem <= rem_sel << 1;
          q   <= {q[M:0], t_ge};
          if (cnt == LAST_IT)
            state <= NORM;
          else
            cnt <= cnt + NW'(1);
        end
        // Normalise: a quotient below 1.0 costs one exponent step.
        NORM: begin
          if (q[M+1])
            z_r <= pack_z(sign, e_tmp, q[M:1]);
          else
            z_r <= pack_z(sign, e_tmp - EXP_ONE, q[M-1:0]);
          out_special_r <= 1'b0;
          out_valid_r   <= 1'b1;
          state         <= DONE;
        end
        // Hold the result until the consumer takes it.
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fphub_div_sequencer.sv
// Scoreboard bench for fphub_div_sequencer: directed cases, backpressure,
// mid-division reset and a short randomised run against a division model.
module tb_fphub_div_sequencer;
  localparam int M  = 23;
  localparam int E  = 8;
  localparam int SC = 7;
  localparam int W  = E + M + 1;
  localparam int CW = $clog2(SC);
  localparam int LAT_NORMAL  = M + 4;
  localparam int LAT_SPECIAL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fphub_div_sequencer_if #(.M(M), .E(E), .special_case(SC)) bus();

  fphub_div_sequencer #(.M(M), .E(E), .special_case(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];   // {out_special, Z}

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: integer division of the HUB significands, then truncate and clamp.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [CW-1:0] xc, input logic [CW-1:0] yc,
                                       input logic [W-1:0] sr);
    longint mx, my, qv, ex;
    logic s;
    logic [M-1:0] mant;
    if (xc != 0 || yc != 0) return {1'b1, sr};
    s  = x[W-1] ^ y[W-1];
    mx = (longint'(1) << (M + 1)) | (longint'(x[M-1:0]) << 1) | longint'(1);
    my = (longint'(1) << (M + 1)) | (longint'(y[M-1:0]) << 1) | longint'(1);
    qv = (mx << (M + 1)) / my;
    ex = longint'(x[W-2:M]) - longint'(y[W-2:M]) + longint'((1 << (E - 1)) - 1);
    if (((qv >> (M + 1)) & 1) != 0) begin
      mant = M'(qv >> 1);
    end else begin
      mant = M'(qv);
      ex   = ex - 1;
    end
    if (ex >= longint'((1 << E) - 1)) return {1'b0, s, {E{1'b1}}, {M{1'b1}}};
    if (ex <= 0) return {1'b0, s, {(E + M){1'b0}}};
    return {1'b0, s, E'(ex), mant};
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accept edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [CW-1:0] xc, input logic [CW-1:0] yc,
                      input logic [W-1:0] sr, input logic [W:0] want);
    bus.X              = x;
    bus.Y              = y;
    bus.X_special_case = xc;
    bus.Y_special_case = yc;
    bus.special_result = sr;
    bus.in_valid       = 1'b1;
    @(negedge clk);
    check_val("accept_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_lat, input int hold);
    int lat;
    logic [W-1:0] z0;
    logic [W:0] want;
    lat = 0;
    bus.out_ready = (hold == 0);
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 100);
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    z0 = bus.Z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid       = 1'b1;
      bus.X              = $urandom;
      bus.X_special_case = CW'(1);
      bus.special_result = $urandom;
      @(negedge clk);
      check_val({tag, "_hold_z"}, 64'(bus.Z), 64'(z0));
      check_val({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
      check_val({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_val({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_val({tag, "_z"}, 64'(bus.Z), 64'(want[W-1:0]));
    check_val({tag, "_special"}, 64'(bus.out_special), 64'(want[W]));
    @(posedge clk);
    #1;
    check_val({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
    check_val({tag, "_idle_vld"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y, sr;
    logic [CW-1:0] xc, yc;

    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b1;
    bus.X              = '0;
    bus.Y              = '0;
    bus.X_special_case = '0;
    bus.Y_special_case = '0;
    bus.special_result = '0;

    #2;
    check_val("rst_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_vld", 64'(bus.out_valid), 64'd0);
    check_val("rst_z", 64'(bus.Z), 64'd0);
    check_val("rst_special", 64'(bus.out_special), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2.0 / 1.0
    send(32'h40000000, 32'h3F800000, '0, '0, '0, {1'b0, 32'h40000000});
    collect("two_by_one", LAT_NORMAL, 0);

    // Quotient below 1.0: exponent 126, mantissa from q[22:0]
    send(32'h3F800000, 32'h3FFFFFFF, '0, '0, '0, {1'b0, 32'h3F000000});
    collect("norm_shift", LAT_NORMAL, 0);

    send(32'h12345678, 32'h3F800000, CW'(3), '0, 32'hFFFFFFFF, {1'b1, 32'hFFFFFFFF});
    collect("special_x", LAT_SPECIAL, 0);

    send(32'h3F800000, 32'h40000000, '0, CW'(5), 32'h7FC00000, {1'b1, 32'h7FC00000});
    collect("special_y", LAT_SPECIAL, 0);

    send(32'h7F000000, 32'h00800000, '0, '0, '0, {1'b0, 32'h7FFFFFFF});
    collect("overflow", LAT_NORMAL, 0);

    send(32'h80800000, 32'h7F000000, '0, '0, '0, {1'b0, 32'h80000000});
    collect("underflow", LAT_NORMAL, 0);

    x = 32'hC0A00000;
    y = 32'h40000000;
    send(x, y, '0, '0, '0, model(x, y, '0, '0, '0));
    collect("backpressure", LAT_NORMAL, 5);

    // Abort a division partway through, then run a clean transaction.
    send(32'h40400000, 32'h3F800000, '0, '0, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_val("abort_vld", 64'(bus.out_valid), 64'd0);
    check_val("abort_z", 64'(bus.Z), 64'd0);
    check_val("abort_special", 64'(bus.out_special), 64'd0);
    check_val("abort_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h40000000, 32'h3F800000, '0, '0, '0, {1'b0, 32'h40000000});
    collect("after_abort", LAT_NORMAL, 0);

    for (int i = 0; i < 10; i++) begin
      x  = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
      y  = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
      xc = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(1, 6)) : CW'(0);
      yc = ($urandom_range(0, 5) == 0) ? CW'($urandom_range(1, 6)) : CW'(0);
      sr = $urandom;
      send(x, y, xc, yc, sr, model(x, y, xc, yc, sr));
      collect($sformatf("rand%0d", i), (xc != 0 || yc != 0) ? LAT_SPECIAL : LAT_NORMAL, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
